// File: rtl/spike_time_capture_if.sv
// Result bus of the spike time capture block: captured word, earliest
// arrival time, empty-window flag and a valid/ready handshake.
interface spike_time_capture_if #(
   parameter int LEN = 8
);
   localparam int TW = $clog2(LEN + 1);

   logic            valid;
   logic            ready;
   logic [0:LEN-1]  word_out;
   logic [TW-1:0]   first_time;
   logic            no_spike;

   modport master (
      output valid,
      output word_out,
      output first_time,
      output no_spike,
      input  ready
   );

   modport slave (
      input  valid,
      input  word_out,
      input  first_time,
      input  no_spike,
      output ready
   );
endinterface

// File: rtl/spike_time_capture.sv
// Race-logic spike receiver: samples spike_in for LEN cycles, rebuilds the
// [0:LEN-1] spike word and reports the binary time of the earliest spike
// (LEN when the window was empty). Result is held on a valid/ready bus.
// Optional build macro SPIKE_CAP_ONE_HOT_EN: word_out keeps only the
// earliest spike (one-hot or zero); otherwise it is the union of all spikes.
module spike_time_capture #(
   parameter  int LEN = 8,
   localparam int TW  = $clog2(LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 spike_in,
   output logic                 busy,
   spike_time_capture_if.master res
);
   localparam int CW = $clog2(LEN);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [0:LEN-1]  shadow_word_q, shadow_word_d;
   logic            first_found_q, first_found_d;
   logic [TW-1:0]   shadow_first_q, shadow_first_d;
   logic [0:LEN-1]  word_out_q, word_out_d;
   logic [TW-1:0]   first_time_q, first_time_d;
   logic            no_spike_q, no_spike_d;

   logic            valid;
   logic            last_sample;
   logic            start_win;
   logic [0:LEN-1]  word_cap;
   logic            found_cap;
   logic [TW-1:0]   first_cap;

   assign last_sample = (cnt_q == CW'(LEN - 1));
   // A new window opens from IDLE, or from HOLD in the same cycle the result is accepted.
   assign start_win   = start && ((state_q == IDLE) || ((state_q == HOLD) && res.ready));

   // State register; reset aborts any window in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CAPTURE;
         CAPTURE: if (last_sample) state_d = HOLD;
         HOLD:    if (res.ready) state_d = start ? CAPTURE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy during the sampling window, valid while a result is held.
   always_comb begin
      busy  = (state_q == CAPTURE);
      valid = (state_q == HOLD);
   end

   // Shadow capture and result latch; the current sample is folded in so the
   // final edge of the window lands in bit LEN-1 of the published word.
   always_comb begin
      cnt_d          = cnt_q;
      shadow_word_d  = shadow_word_q;
      first_found_d  = first_found_q;
      shadow_first_d = shadow_first_q;
      word_out_d     = word_out_q;
      first_time_d   = first_time_q;
      no_spike_d     = no_spike_q;

      word_cap = shadow_word_q;
      for (int i = 0; i < LEN; i++) begin
         if (CW'(i) == cnt_q) word_cap[i] = spike_in;
      end
      found_cap = first_found_q | spike_in;
      first_cap = (spike_in && !first_found_q) ? TW'(cnt_q) : shadow_first_q;

      if (start_win) begin
         cnt_d          = '0;
         shadow_word_d  = '0;
         first_found_d  = 1'b0;
         shadow_first_d = TW'(LEN);
      end else if (state_q == CAPTURE) begin
         shadow_word_d  = word_cap;
         first_found_d  = found_cap;
         shadow_first_d = first_cap;
         if (last_sample) begin
`ifdef SPIKE_CAP_ONE_HOT_EN
            for (int i = 0; i < LEN; i++) begin
               word_out_d[i] = found_cap && (TW'(i) == first_cap);
            end
`else
            word_out_d = word_cap;
`endif
            first_time_d = first_cap;
            no_spike_d   = !found_cap;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         shadow_word_q  <= '0;
         first_found_q  <= 1'b0;
         shadow_first_q <= '0;
         word_out_q     <= '0;
         first_time_q   <= '0;
         no_spike_q     <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         shadow_word_q  <= shadow_word_d;
         first_found_q  <= first_found_d;
         shadow_first_q <= shadow_first_d;
         word_out_q     <= word_out_d;
         first_time_q   <= first_time_d;
         no_spike_q     <= no_spike_d;
      end
   end

   assign res.valid      = valid;
   assign res.word_out   = word_out_q;
   assign res.first_time = first_time_q;
   assign res.no_spike   = no_spike_q;
endmodule

// File: tb/tb_spike_time_capture.sv
// Scoreboard bench for spike_time_capture (LEN=8): directed spike patterns
// with hand-computed results, backpressure, back-to-back and async reset.
module tb_spike_time_capture;
   localparam int LEN = 8;

   typedef struct packed {
      logic [0:7] word;
      logic [3:0] first;
      logic       none;
   } exp_t;

   logic clk;
   logic rst;
   logic start;
   logic spike_in;
   logic busy;

   exp_t sb[$];
   int   vectors;
   int   miscompares;

   spike_time_capture_if #(.LEN(LEN)) bus ();

   spike_time_capture #(.LEN(LEN)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .spike_in (spike_in),
      .busy     (busy),
      .res      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [0:7] w, input logic [3:0] f, input logic n);
      exp_t e;
      e.word  = w;
      e.first = f;
      e.none  = n;
      sb.push_back(e);
   endtask

   // Drive one window of samples (already in CAPTURE), then confirm the result is presented.
   task automatic capture_body(input logic [0:7] pat);
      for (int t = 0; t < LEN; t++) begin
         spike_in = pat[t];
         check("busy_in_window", {31'd0, busy}, 32'd1);
         check("valid_low_in_window", {31'd0, bus.valid}, 32'd0);
         tick();
      end
      spike_in = 1'b0;
      check("valid_after_window", {31'd0, bus.valid}, 32'd1);
      check("busy_after_window", {31'd0, busy}, 32'd0);
   endtask

   // Full transaction from IDLE with ready held high.
   task automatic run_window(input logic [0:7] pat, input logic [0:7] w,
                             input logic [3:0] f, input logic n);
      push_exp(w, f, n);
      start = 1'b1;
      tick();
      start = 1'b0;
      capture_body(pat);
      tick();
      check("valid_after_accept", {31'd0, bus.valid}, 32'd0);
   endtask

   // Monitor: compare every accepted result against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && bus.valid && bus.ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: word %0h with empty scoreboard", bus.word_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("word_out", {24'd0, bus.word_out}, {24'd0, e.word});
            check("first_time", {28'd0, bus.first_time}, {28'd0, e.first});
            check("no_spike", {31'd0, bus.no_spike}, {31'd0, e.none});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      start       = 1'b0;
      spike_in    = 1'b0;
      bus.ready   = 1'b0;
      tick();
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, bus.valid}, 32'd0);
      check("rst_no_spike", {31'd0, bus.no_spike}, 32'd0);
      check("rst_word", {24'd0, bus.word_out}, 32'd0);
      check("rst_first", {28'd0, bus.first_time}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Single spike at sample 1; spike_in ignored in IDLE before start.
      bus.ready = 1'b1;
      spike_in  = 1'b1;
      tick();
      check("idle_ignores_spike", {31'd0, busy}, 32'd0);
      spike_in = 1'b0;
      run_window(8'b0100_0000, 8'b0100_0000, 4'd1, 1'b0);

      // Multiple spikes at samples 0,1,5,6.
`ifdef SPIKE_CAP_ONE_HOT_EN
      run_window(8'b1100_0110, 8'b1000_0000, 4'd0, 1'b0);
`else
      run_window(8'b1100_0110, 8'b1100_0110, 4'd0, 1'b0);
`endif

      // Empty window: infinity time.
      run_window(8'b0000_0000, 8'b0000_0000, 4'd8, 1'b1);

      // Spike only on the final edge of the window.
      run_window(8'b0000_0001, 8'b0000_0001, 4'd7, 1'b0);

      // Backpressure: hold result while start is pulsed without ready.
      bus.ready = 1'b0;
      push_exp(8'b0010_0000, 4'd2, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      capture_body(8'b0010_0000);
      for (int k = 0; k < 5; k++) begin
         start = 1'b1;
         tick();
         check("bp_valid_held", {31'd0, bus.valid}, 32'd1);
         check("bp_no_capture", {31'd0, busy}, 32'd0);
         check("bp_word_stable", {24'd0, bus.word_out}, 32'h20);
         check("bp_first_stable", {28'd0, bus.first_time}, 32'd2);
      end

      // Accept and restart in the same cycle: back-to-back window.
      push_exp(8'b0000_1000, 4'd4, 1'b0);
      bus.ready = 1'b1;
      tick();
      start = 1'b0;
      capture_body(8'b0000_1000);
      tick();
      check("b2b_idle_valid", {31'd0, bus.valid}, 32'd0);
      check("b2b_idle_busy", {31'd0, busy}, 32'd0);

      // Async reset mid-window after a spike at sample 2.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 3; t++) begin
         spike_in = (t == 2);
         tick();
      end
      spike_in = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_valid", {31'd0, bus.valid}, 32'd0);
      check("arst_word", {24'd0, bus.word_out}, 32'd0);
      check("arst_first", {28'd0, bus.first_time}, 32'd0);
      check("arst_no_spike", {31'd0, bus.no_spike}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("arst_idle", {31'd0, busy}, 32'd0);
      run_window(8'b0000_0000, 8'b0000_0000, 4'd8, 1'b1);

      repeat (3) tick();
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spike_time_capture.md
Name: spike_time_capture

Overview:
- Receiver for the temporal spike domain. Samples a serial race-logic spike line over a window of LEN cycles.
- Rebuilds the parallel spike word in the [0:LEN-1] format consumed by the barrel shifter; bit t is set when a spike arrived at time stamp t.
- Also reports the binary arrival time of the earliest spike, i.e. the inverse of the one-hot/binary conversion used on the shift path.
- Sits between a spiking source (neuron or column output) and downstream shift/compare logic; valid/ready handshake on the output side.

Parameters:
- LEN, 8: capture window length in cycles; width of word_out; must be >= 2.
- TW, $clog2(LEN+1): width of first_time; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a capture window; sampled only in IDLE, or in HOLD together with ready.
- spike_in  input  1  serial spike line; level-sampled once per cycle during CAPTURE.
- busy  output  1  high while in CAPTURE.
- word_out  output  [0:LEN-1]  captured spike word; bit t = spike at time stamp t.
- first_time  output  TW  binary time of earliest spike; LEN when no spike (race-logic "infinity").
- no_spike  output  1  high when the captured window contained no spike.
- valid  output  1  result available; held until accepted.
- ready  input  1  downstream accept; transfer occurs when valid && ready.

Behaviour:
- Reset: state=IDLE; busy=0, valid=0, no_spike=0, word_out=0, first_time=0; counter and shadow registers cleared. Asserting rst mid-CAPTURE or mid-HOLD aborts immediately; the partial result is discarded.
- States: IDLE, CAPTURE, HOLD (3-state FSM, registered state).
- IDLE:
  - start=1 at edge E0 -> CAPTURE.
  - On that edge: cnt=0, shadow word=0, first_found=0, shadow first_time=LEN.
  - spike_in is ignored in IDLE.
- CAPTURE:
  - At edges E1..E_LEN, spike_in is written to shadow bit cnt, and cnt increments.
  - On the first sampled spike_in=1 in the window, shadow first_time=cnt and first_found=1. Later spikes do not change first_time.
  - start is ignored during CAPTURE.
  - At edge E_LEN (cnt==LEN-1): shadow values plus the current sample are copied to word_out/first_time/no_spike; valid=1; state -> HOLD.
  - The sample taken at E_LEN is included in the result (bit LEN-1).
- Latency: valid is high in the cycle following edge E_LEN, i.e. LEN+1 cycles after the start cycle. busy is high for exactly LEN cycles.
- HOLD:
  - word_out, first_time, no_spike and valid stay stable while ready=0.
  - valid && ready with start=0: valid=0 -> IDLE. Outputs keep their last values.
  - valid && ready with start=1: valid=0, and a new window begins (-> CAPTURE, counters cleared). This gives back-to-back captures with no idle cycle.
  - start without ready is ignored.
- no_spike = (word_out==0); it is always consistent with first_time==LEN.
- cnt width $clog2(LEN); it never exceeds LEN-1 and does not wrap.

Optional Feature:
- Macro: SPIKE_CAP_ONE_HOT_EN.
- Defined: word_out keeps only the earliest spike, so it is one-hot or all-zero. Bits after first_time are forced to 0 on capture. This gives a single-spike input for one-hot shift paths.
- Undefined: word_out holds the union of all spikes in the window.
- first_time and no_spike behave identically in both builds.

Test Plan:
- LEN=8; start pulse; spike_in=1 only at window sample 1 -> after 9 cycles valid=1, word_out[0:7]=8'b0100_0000, first_time=1, no_spike=0.
- Spikes at samples 0,1,5,6:
  - without macro -> word_out=8'b1100_0110, first_time=0.
  - with SPIKE_CAP_ONE_HOT_EN -> word_out=8'b1000_0000, first_time=0.
- No spike in window -> word_out=0, first_time=8, no_spike=1.
- Spike only at sample 7 (last edge) -> word_out=8'b0000_0001, first_time=7.
- Backpressure: ready=0 for 5 cycles in HOLD with start pulsed -> outputs unchanged, no new capture. Then ready=1 with start=1 in the same cycle -> valid drops for exactly LEN cycles, busy=1, and the second result is correct.
- rst asserted asynchronously at sample 3 of a window with a spike at 2 -> outputs immediately 0, state IDLE. The next capture with no spikes yields first_time=8 (no stale spike).
